// File: rtl/ywrite_back_pkg.sv
// ypkg: shared widths, slot field layout and FSM encoding for the Y write-back engine
package ypkg;
  localparam int ADDR_W = 11;
  localparam int SLOT_W = 64;
  localparam int NSLOT = 4;
  localparam int ROW_W = SLOT_W * NSLOT;
  localparam int COL_HI = 63;
  localparam int REAL_HI = 47;
  localparam int IMG_HI = 23;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD = 3'd1;
  localparam logic [2:0] ST_CAP = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_WR = 3'd4;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD = ST_RD,
    CAP = ST_CAP,
    HOLD = ST_HOLD,
    WR = ST_WR
  } state_t;
endpackage

// File: rtl/ywrite_back_merge.sv
// ySlotMerge: replaces every one-hot selected slot of a row with {col, val}
module ySlotMerge
  import ypkg::*;
(
  input  logic [ROW_W-1:0]         row,
  input  logic [NSLOT-1:0]         one_hot,
  input  logic [COL_HI-REAL_HI-1:0] col,
  input  logic [REAL_HI:0]         val,
  output logic [ROW_W-1:0]         merged
);
  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    assign merged[k*SLOT_W +: SLOT_W] = one_hot[k] ? {col, val} : row[k*SLOT_W +: SLOT_W];
  end
endmodule

// File: rtl/ywrite_back.sv
// ywrite_back: read-modify-write of Y SRAM rows, coalescing consecutive same-row updates
module ywrite_back
  import ypkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [NSLOT-1:0]  wb_oneHot,
  input  logic [15:0]       wb_col,
  input  logic [47:0]       wb_val,
  input  logic              wb_last,
  output logic              ySRAM_rdEn,
  output logic [ADDR_W-1:0] ySRAM_rdAddr,
  input  logic [ROW_W-1:0]  ySRAM_rowRead,
  output logic              ySRAM_wrEn,
  output logic [ADDR_W-1:0] ySRAM_wrAddr,
  output logic [ROW_W-1:0]  ySRAM_rowWrite,
  output logic              wbDoneFlag,
  output logic [11:0]       rowsWritten
);
  state_t state, next;
  logic [ADDR_W-1:0] cur_addr;
  logic [NSLOT-1:0] pend_hot;
  logic [15:0] pend_col;
  logic [47:0] pend_val;
  logic last_seen, accept, cap;
  logic [ROW_W-1:0] row_buf, merged;
  always_comb begin
    wb_ready = !reset & (state == IDLE | (state == HOLD & wb_addr == cur_addr & !last_seen));
    accept = wb_valid & wb_ready;
    cap = state == CAP;
    next = state == IDLE ? (accept ? RD : IDLE) :
           state == RD   ? CAP :
           state == CAP  ? HOLD :
           state == HOLD ? (accept ? HOLD : WR) : IDLE;
  end
  // CAP merges the latched update into the fresh read; HOLD merges live updates into row_buf
  ySlotMerge u_merge (
    .row(cap ? ySRAM_rowRead : row_buf),
    .one_hot(cap ? pend_hot : wb_oneHot),
    .col(cap ? pend_col : wb_col),
    .val(cap ? pend_val : wb_val),
    .merged(merged)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      pend_hot <= '0;
      pend_col <= '0;
      pend_val <= '0;
      last_seen <= 1'b0;
      row_buf <= '0;
      ySRAM_rdEn <= 1'b0;
      ySRAM_rdAddr <= '0;
      ySRAM_wrEn <= 1'b0;
      ySRAM_wrAddr <= '0;
      ySRAM_rowWrite <= '0;
      wbDoneFlag <= 1'b0;
      rowsWritten <= '0;
    end else begin
      state <= next;
      ySRAM_rdEn <= next == RD;
      ySRAM_wrEn <= next == WR;
      wbDoneFlag <= state == WR & last_seen;
      last_seen <= state == WR ? 1'b0 : accept ? (state == HOLD & last_seen) | wb_last : last_seen;
      row_buf <= (cap | (state == HOLD & accept)) ? merged : row_buf;
      if (state == IDLE & accept) begin
        cur_addr <= wb_addr;
        pend_hot <= wb_oneHot;
        pend_col <= wb_col;
        pend_val <= wb_val;
        ySRAM_rdAddr <= wb_addr;
      end
      if (next == WR) begin
        ySRAM_wrAddr <= cur_addr;
        ySRAM_rowWrite <= row_buf;
        rowsWritten <= rowsWritten + 12'd1;
      end
    end
  end
endmodule

// File: tb/tb_ywrite_back.sv
// tb_ywrite_back: directed checks of ywrite_back against a behavioural Y SRAM
module tb_ywrite_back;
  logic clock = 0, reset = 1, wb_valid = 0, wb_last = 0;
  logic wb_ready, ySRAM_rdEn, ySRAM_wrEn, wbDoneFlag;
  logic [10:0] wb_addr = 0, ySRAM_rdAddr, ySRAM_wrAddr;
  logic [3:0] wb_oneHot = 0;
  logic [15:0] wb_col = 0;
  logic [47:0] wb_val = 0;
  logic [255:0] ySRAM_rowRead = 0, ySRAM_rowWrite;
  logic [11:0] rowsWritten;
  logic [255:0] mem [0:2047];
  int checks = 0, errors = 0, rd_cnt = 0, wr_cnt = 0;
  int rd0, wr0;
  logic [255:0] exp_row;
  localparam logic [63:0] A64 = {16{4'hA}};

  ywrite_back dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_oneHot(wb_oneHot), .wb_col(wb_col), .wb_val(wb_val),
    .wb_last(wb_last), .ySRAM_rdEn(ySRAM_rdEn), .ySRAM_rdAddr(ySRAM_rdAddr),
    .ySRAM_rowRead(ySRAM_rowRead), .ySRAM_wrEn(ySRAM_wrEn), .ySRAM_wrAddr(ySRAM_wrAddr),
    .ySRAM_rowWrite(ySRAM_rowWrite), .wbDoneFlag(wbDoneFlag), .rowsWritten(rowsWritten)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ySRAM_rdEn) begin
      ySRAM_rowRead <= mem[ySRAM_rdAddr];
      rd_cnt <= rd_cnt + 1;
    end
    if (ySRAM_wrEn) begin
      mem[ySRAM_wrAddr] <= ySRAM_rowWrite;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [10:0] a, input logic [3:0] h, input logic [15:0] c,
                      input logic [47:0] v, input logic l);
    logic ok;
    wb_valid = 1; wb_addr = a; wb_oneHot = h; wb_col = c; wb_val = v; wb_last = l;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (wb_ready) begin
        ok = 1;
        break;
      end
      tick;
    end
    check("ready_wait", {255'd0, ok}, 256'd1);
    tick;
    wb_valid = 0;
  endtask

  task automatic wait_wr;
    for (int n = 0; n < 30; n++) begin
      if (ySRAM_wrEn) break;
      tick;
    end
    check("wr_seen", {255'd0, ySRAM_wrEn}, 256'd1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {4{A64}};
    mem[9] = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h0FFF_0000_0000_0000};
    mem[2] = {64'h2C2C_2C2C_2C2C_2C2C, 64'h2B2B_2B2B_2B2B_2B2B,
              64'h2A2A_2A2A_2A2A_2A2A, 64'h2929_2929_2929_2929};
    mem[7] = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
              64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
    tick;
    tick;
    check("rst_ready", {255'd0, wb_ready}, 256'd0);
    check("rst_wren", {255'd0, ySRAM_wrEn}, 256'd0);
    check("rst_rows", {244'd0, rowsWritten}, 256'd0);
    check("rst_rowwrite", ySRAM_rowWrite, 256'd0);
    reset = 0;
    tick;
    check("ready_after_rst", {255'd0, wb_ready}, 256'd1);

    send(11'd5, 4'b0010, 16'd7, 48'h000001_FFFFFF, 1'b0);
    check("t1_rden", {255'd0, ySRAM_rdEn}, 256'd1);
    check("t1_rdaddr", {245'd0, ySRAM_rdAddr}, 256'd5);
    tick;
    tick;
    check("t1_no_wr_early", {255'd0, ySRAM_wrEn}, 256'd0);
    tick;
    check("t1_wren_t4", {255'd0, ySRAM_wrEn}, 256'd1);
    check("t1_wraddr", {245'd0, ySRAM_wrAddr}, 256'd5);
    check("t1_row", ySRAM_rowWrite, {A64, A64, 64'h0007_0000_01FF_FFFF, A64});
    check("t1_rows", {244'd0, rowsWritten}, 256'd1);
    tick;
    check("t1_no_done", {255'd0, wbDoneFlag}, 256'd0);
    check("t1_ready_t5", {255'd0, wb_ready}, 256'd1);

    rd0 = rd_cnt; wr0 = wr_cnt;
    send(11'd9, 4'b0001, 16'd1, 48'hAAAAAA_BBBBBB, 1'b0);
    send(11'd9, 4'b1000, 16'd3, 48'h000003_000003, 1'b0);
    send(11'd9, 4'b0001, 16'd2, 48'h123456_654321, 1'b1);
    wait_wr;
    check("t2_wraddr", {245'd0, ySRAM_wrAddr}, 256'd9);
    check("t2_row", ySRAM_rowWrite, {64'h0003_0000_0300_0003, 64'h2222_2222_2222_2222,
                                     64'h1111_1111_1111_1111, 64'h0002_1234_5665_4321});
    tick;
    check("t2_done", {255'd0, wbDoneFlag}, 256'd1);
    tick;
    check("t2_done_1cyc", {255'd0, wbDoneFlag}, 256'd0);
    check("t2_one_rd", rd_cnt - rd0, 256'd1);
    check("t2_one_wr", wr_cnt - wr0, 256'd1);

    wr0 = wr_cnt;
    send(11'd2, 4'b0100, 16'd5, 48'h000000_000001, 1'b0);
    wb_valid = 1; wb_addr = 11'd3; wb_oneHot = 4'b0001; wb_col = 16'd6; wb_val = 48'hFFFFFF_000000;
    tick;
    tick;
    check("t3_stall_hold", {255'd0, wb_ready}, 256'd0);
    tick;
    check("t3_wr2", {255'd0, ySRAM_wrEn}, 256'd1);
    check("t3_wraddr2", {245'd0, ySRAM_wrAddr}, 256'd2);
    check("t3_row2", ySRAM_rowWrite, {64'h2C2C_2C2C_2C2C_2C2C, 64'h0005_0000_0000_0001,
                                      64'h2A2A_2A2A_2A2A_2A2A, 64'h2929_2929_2929_2929});
    check("t3_stall_wr", {255'd0, wb_ready}, 256'd0);
    tick;
    check("t3_ready_idle", {255'd0, wb_ready}, 256'd1);
    send(11'd3, 4'b0001, 16'd6, 48'hFFFFFF_000000, 1'b0);
    wait_wr;
    check("t3_wraddr3", {245'd0, ySRAM_wrAddr}, 256'd3);
    check("t3_row3", ySRAM_rowWrite, {A64, A64, A64, 64'h0006_FFFF_FF00_0000});
    tick;
    check("t3_two_wr", wr_cnt - wr0, 256'd2);

    send(11'd7, 4'b0000, 16'hBEEF, 48'h111111_222222, 1'b1);
    wait_wr;
    exp_row = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
               64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
    check("t4_unchanged", ySRAM_rowWrite, exp_row);
    check("t4_wraddr", {245'd0, ySRAM_wrAddr}, 256'd7);
    tick;
    check("t4_done", {255'd0, wbDoneFlag}, 256'd1);
    check("t4_rows", {244'd0, rowsWritten}, 256'd5);

    wr0 = wr_cnt;
    send(11'd11, 4'b0001, 16'd9, 48'h1, 1'b1);
    tick;
    reset = 1;
    tick;
    check("t5_wren", {255'd0, ySRAM_wrEn}, 256'd0);
    check("t5_rden", {255'd0, ySRAM_rdEn}, 256'd0);
    check("t5_done", {255'd0, wbDoneFlag}, 256'd0);
    check("t5_rows", {244'd0, rowsWritten}, 256'd0);
    check("t5_rowwrite", ySRAM_rowWrite, 256'd0);
    check("t5_wraddr", {245'd0, ySRAM_wrAddr}, 256'd0);
    check("t5_ready_rst", {255'd0, wb_ready}, 256'd0);
    reset = 0;
    tick;
    check("t5_ready", {255'd0, wb_ready}, 256'd1);
    for (int i = 0; i < 8; i++) tick;
    check("t5_no_wr", wr_cnt - wr0, 256'd0);
    check("t5_no_done", {255'd0, wbDoneFlag}, 256'd0);

    for (int i = 0; i < 4095; i++) send(11'(i), 4'b0000, 16'd0, 48'd0, 1'b0);
    wait_wr;
    check("t6_rows_4095", {244'd0, rowsWritten}, 256'd4095);
    send(11'd100, 4'b0000, 16'd0, 48'd0, 1'b0);
    wait_wr;
    check("t6_wrap", {244'd0, rowsWritten}, 256'd0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ywrite_back.md
# ywrite_back

Write-back engine for the Y-matrix SRAM. It accepts updated Y entries (complex 48-bit value, column tag, row address and one-hot slot select) from the update-Y datapath and performs a read-modify-write of the 256-bit Y SRAM row. Consecutive updates to the same row are coalesced into one write. It is the writer-side counterpart of the row-read/address-decode path. It sits between the update datapath output and the Y SRAM write port.

## Interface
Parameters:
- ADDR_W, 11, Y SRAM row address width
- SLOT_W, 64, bits per row slot; slot = {col[15:0], real[23:0], img[23:0]}
- NSLOT, 4, slots per row (row width = SLOT_W*NSLOT = 256)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  update presented
- wb_ready  out  1  update accepted when wb_valid & wb_ready
- wb_addr  in  11  target Y SRAM row
- wb_oneHot  in  4  slot select; bit k selects slot k
- wb_col  in  16  column tag written into slot
- wb_val  in  48  {real[23:0], img[23:0]}
- wb_last  in  1  final update of the batch
- ySRAM_rdEn  out  1  read strobe
- ySRAM_rdAddr  out  11  read row
- ySRAM_rowRead  in  256  read data, valid the cycle after ySRAM_rdEn
- ySRAM_wrEn  out  1  write strobe
- ySRAM_wrAddr  out  11  write row
- ySRAM_rowWrite  out  256  write data
- wbDoneFlag  out  1  one-cycle pulse after the wb_last row is written
- rowsWritten  out  12  count of SRAM row writes, wraps at 4095→0

## Operation
- States: IDLE, RD, CAP, HOLD, WR.
- IDLE: wb_ready=1. On accept, latch curAddr, pending {oneHot, col, val}, lastSeen=wb_last → RD.
- RD: ySRAM_rdEn=1, ySRAM_rdAddr=curAddr, wb_ready=0 → CAP.
- CAP: rowBuf ← ySRAM_rowRead with pending slot(s) replaced by {col, val}. wb_ready=0 → HOLD.
- HOLD: wb_ready = (wb_addr==curAddr) & !lastSeen.
  - If accepted: merge into rowBuf, lastSeen |= wb_last, stay in HOLD.
  - Otherwise (no valid, different addr, or lastSeen) → WR.
- WR: ySRAM_wrEn=1, ySRAM_wrAddr=curAddr, ySRAM_rowWrite=rowBuf, rowsWritten+1, wb_ready=0 → IDLE.
  - If lastSeen, wbDoneFlag=1 in the following cycle; lastSeen cleared.
- Slot k occupies rowBuf[64k+63 : 64k]. Multiple oneHot bits: every selected slot gets the same word. oneHot=0: the update is accepted and counts for coalescing/last, but the row is unchanged; the row is still written back.
- Within one HOLD, later updates to the same slot overwrite earlier ones (last wins).
- Slots that are not selected pass through bit-exact from the read data.

## Timing
- Reset values: state=IDLE, wb_ready=0 during the reset cycle and 1 from the first cycle after, ySRAM_rdEn=0, ySRAM_wrEn=0, addresses 0, ySRAM_rowWrite=0, wbDoneFlag=0, rowsWritten=0, lastSeen=0, rowBuf=0.
- Isolated update: accept at cycle t, rdEn at t+1, capture at t+2, HOLD at t+3, wrEn at t+4. Next accept at t+5 at the earliest. Throughput is 1 row per 5 cycles with no coalescing.
- Coalesced burst of N same-row updates: 1 read, 1 write, N+4 cycles.
- Read/write hazard: a write in WR always precedes the next RD by ≥2 cycles, so there is no forwarding.
- Outputs ySRAM_* and wbDoneFlag are registered. wb_ready is combinational from state, curAddr and wb_addr.
- Reset mid-operation: abort immediately. The in-flight row is discarded, there is no wrEn, and no done pulse.

## Structure
- Shared package ypkg: ADDR_W, SLOT_W, NSLOT, the slot field offsets (COL_HI=63, REAL_HI=47, IMG_HI=23), and the state encoding (3-bit localparams).
- Sub-module ySlotMerge: combinational (row[255:0], oneHot[3:0], col, val) → row'. Used in both CAP and HOLD.

## Test plan
- Single update addr=5, oneHot=0010, col=7, val=0x000001_FFFFFF, with preloaded row all-A's: wrEn at t+4; slot1 = 0x0007_000001FFFFFF; slots 0, 2 and 3 unchanged; rowsWritten=1.
- Three back-to-back updates to addr=9 on slots 0, 3, 0 (second slot-0 val=0x123456_654321), last on the third: one rdEn, one wrEn; slot0 holds the second value; wbDoneFlag pulses the cycle after wrEn.
- Updates addr=2, then addr=3 presented in HOLD: addr=3 is stalled (wb_ready=0); row 2 is written; addr=3 is accepted in IDLE the next cycle; two writes in total.
- oneHot=0000 with wb_last=1: the row is rewritten unchanged, and wbDoneFlag still pulses.
- Reset asserted during CAP: no wrEn ever issued for that row; all outputs at reset values the next cycle; wb_ready=1 the cycle after reset deasserts.
- 4096 isolated writes: rowsWritten wraps to 0.
